// File: rtl/matrix_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_scan_decoder
//  Purpose  : Receive-side decoder for the 8x8 LED matrix row/column scan and
//             the dice 7-segment digit. It rebuilds frames from the row
//             strobes, extracts the player cell by masking the static board
//             pattern, and decodes the dice digit.
//  Options  : SCAN_DECODER_TIMEOUT_EN - adds a scan watchdog (err_timeout).
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_scan_decoder #(
  parameter int          STABLE_CYCLES  = 4,
  parameter logic [63:0] BOARD          = 64'h0802000081040250,
  parameter int          TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_full,
  input  logic [7:0]  row_in,
  input  logic [7:0]  col_in,
  input  logic [6:0]  hex_in,
  output logic [63:0] frame,
  output logic        frame_valid,
  output logic [5:0]  pos,
  output logic        pos_valid,
  output logic [2:0]  dice,
  output logic        dice_valid,
  output logic        err_row,
  output logic        err_seq,
  output logic        err_multi,
  output logic        err_timeout
);

  // Counters saturate one past STABLE_CYCLES so acceptance fires only once.
  localparam logic [8:0] c_stable = 9'(STABLE_CYCLES);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES < 3) begin : g_param_check
    $error("matrix_scan_decoder: parameter out of range");
  end

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  logic [7:0]  r_row_s1, r_row_s2;
  logic [7:0]  r_col_s1, r_col_s2;
  logic [6:0]  r_hex_s1, r_hex_s2;
  logic [8:0]  r_rc_cnt, r_hex_cnt;
  logic [7:0]  w_row_act;
  logic [2:0]  w_row_idx;
  logic        w_rc_stable, w_row_onehot, w_row_blank;
  logic        w_row_acc, w_row_bad, w_expire;
  state_t      r_state, w_state_nxt;
  logic [2:0]  r_exp, w_exp_nxt;
  logic        w_store, w_commit, w_seq_err;
  logic [63:0] r_shadow;
  logic [63:0] w_ov;
  logic [5:0]  w_ov_idx;
  logic        w_ov_none, w_ov_one;
  logic [2:0]  w_dice_val;

  // Two-flop synchronizers; row idles blank, hex idles all segments off.
  always_ff @(posedge clk or posedge rst_full) begin
    if (rst_full) begin
      r_row_s1 <= 8'hFF;
      r_row_s2 <= 8'hFF;
      r_col_s1 <= 8'h00;
      r_col_s2 <= 8'h00;
      r_hex_s1 <= 7'h7F;
      r_hex_s2 <= 7'h7F;
    end else begin
      r_row_s1 <= row_in;
      r_row_s2 <= r_row_s1;
      r_col_s1 <= col_in;
      r_col_s2 <= r_col_s1;
      r_hex_s1 <= hex_in;
      r_hex_s2 <= r_hex_s1;
    end
  end

  // Stability counters: a new synchronized value counts as 1 on its first cycle.
  always_ff @(posedge clk or posedge rst_full) begin
    if (rst_full) begin
      r_rc_cnt  <= 9'd0;
      r_hex_cnt <= 9'd0;
    end else begin
      if ({r_row_s1, r_col_s1} != {r_row_s2, r_col_s2}) r_rc_cnt <= 9'd1;
      else if (r_rc_cnt <= c_stable)                     r_rc_cnt <= r_rc_cnt + 9'd1;
      if (r_hex_s1 != r_hex_s2)       r_hex_cnt <= 9'd1;
      else if (r_hex_cnt <= c_stable) r_hex_cnt <= r_hex_cnt + 9'd1;
    end
  end

  // Row classification of the stable pattern (active-low one-hot).
  assign w_row_act    = ~r_row_s2;
  assign w_rc_stable  = (r_rc_cnt == c_stable);
  assign w_row_blank  = (r_row_s2 == 8'hFF);
  assign w_row_onehot = !w_row_blank && ((w_row_act & (w_row_act - 8'd1)) == 8'd0);
  assign w_row_acc    = w_rc_stable && w_row_onehot;
  assign w_row_bad    = w_rc_stable && !w_row_onehot && !w_row_blank;

  // Encode the selected row number.
  always_comb begin
    w_row_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_row_act[i]) w_row_idx = 3'(i);
    end
  end

`ifdef SCAN_DECODER_TIMEOUT_EN
  localparam int c_wd_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_wd_w-1:0] r_wd_cnt;
  logic              r_wd_run;
  logic              r_err_timeout;

  // Counter holds cycles since the last accepted row; expiry loses to a new acceptance.
  assign w_expire = r_wd_run && (int'(r_wd_cnt) == TIMEOUT_CYCLES - 1) && !w_row_acc;

  // Watchdog: armed by any accepted row, idles after it expires once.
  always_ff @(posedge clk or posedge rst_full) begin
    if (rst_full) begin
      r_wd_cnt      <= '0;
      r_wd_run      <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_expire;
      if (w_row_acc) begin
        r_wd_cnt <= c_wd_w'(1);
        r_wd_run <= 1'b1;
      end else if (w_expire) begin
        r_wd_run <= 1'b0;
      end else if (r_wd_run) begin
        r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_expire    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Frame FSM state register.
  always_ff @(posedge clk or posedge rst_full) begin
    if (rst_full) begin
      r_state <= HUNT;
      r_exp   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
    end
  end

  // Frame FSM next-state: hunt for row 0, then expect rows strictly in order.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_store     = 1'b0;
    w_commit    = 1'b0;
    w_seq_err   = 1'b0;
    if (w_row_bad) begin
      w_state_nxt = HUNT;
    end else if (w_row_acc) begin
      unique case (r_state)
        HUNT: begin
          if (w_row_idx == 3'd0) begin
            w_store     = 1'b1;
            w_exp_nxt   = 3'd1;
            w_state_nxt = CAPTURE;
          end
        end
        CAPTURE: begin
          if (w_row_idx == r_exp) begin
            w_store = 1'b1;
            if (r_exp == 3'd7) begin
              w_commit    = 1'b1;
              w_exp_nxt   = 3'd0;
              w_state_nxt = HUNT;
            end else begin
              w_exp_nxt = r_exp + 3'd1;
            end
          end else begin
            w_seq_err = 1'b1;
            if (w_row_idx == 3'd0) begin
              w_store   = 1'b1;
              w_exp_nxt = 3'd1;
            end else begin
              w_state_nxt = HUNT;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end else if (w_expire) begin
      w_state_nxt = HUNT;
    end
  end

  // Shadow capture, frame commit and sequencing error pulses.
  always_ff @(posedge clk or posedge rst_full) begin
    if (rst_full) begin
      r_shadow    <= 64'd0;
      frame       <= 64'd0;
      frame_valid <= 1'b0;
      err_row     <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      frame_valid <= w_commit;
      err_row     <= w_row_bad;
      err_seq     <= w_seq_err;
      if (w_store) r_shadow[{w_row_idx, 3'b000} +: 8] <= r_col_s2;
      if (w_commit) frame <= {r_col_s2, 56'd0} | (r_shadow & 64'h00FF_FFFF_FFFF_FFFF);
    end
  end

  // Overlay of non-board cells in the committed frame.
  assign w_ov      = frame & ~BOARD;
  assign w_ov_none = (w_ov == 64'd0);
  assign w_ov_one  = !w_ov_none && ((w_ov & (w_ov - 64'd1)) == 64'd0);

  // Index of the overlay bit (meaningful only when exactly one is set).
  always_comb begin
    w_ov_idx = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (w_ov[i]) w_ov_idx = 6'(i);
    end
  end

  // Player position: update on one cell, hold on none, invalidate on several.
  always_ff @(posedge clk or posedge rst_full) begin
    if (rst_full) begin
      pos       <= 6'd0;
      pos_valid <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      err_multi <= 1'b0;
      if (frame_valid) begin
        if (w_ov_one) begin
          pos       <= w_ov_idx;
          pos_valid <= 1'b1;
        end else if (!w_ov_none) begin
          err_multi <= 1'b1;
          pos_valid <= 1'b0;
        end
      end else if (w_expire) begin
        pos_valid <= 1'b0;
      end
    end
  end

  // Active-low {g..a} dice digits; anything else is not a dice face.
  always_comb begin
    unique case (r_hex_s2)
      7'b1111001: w_dice_val = 3'd1;
      7'b0100100: w_dice_val = 3'd2;
      7'b0110000: w_dice_val = 3'd3;
      7'b0011001: w_dice_val = 3'd4;
      7'b0010010: w_dice_val = 3'd5;
      7'b0000010: w_dice_val = 3'd6;
      default:    w_dice_val = 3'd0;
    endcase
  end

  // Dice outputs refresh only when the hex code has just become stable.
  always_ff @(posedge clk or posedge rst_full) begin
    if (rst_full) begin
      dice       <= 3'd0;
      dice_valid <= 1'b0;
    end else if (r_hex_cnt == c_stable) begin
      dice       <= w_dice_val;
      dice_valid <= (w_dice_val != 3'd0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_scan_decoder
//  Purpose  : Directed self-checking bench for matrix_scan_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_decoder;

  localparam logic [63:0] c_board = 64'h0802000081040250;

  logic        clk;
  logic        rst_full;
  logic [7:0]  row_in;
  logic [7:0]  col_in;
  logic [6:0]  hex_in;
  logic [63:0] frame;
  logic        frame_valid;
  logic [5:0]  pos;
  logic        pos_valid;
  logic [2:0]  dice;
  logic        dice_valid;
  logic        err_row;
  logic        err_seq;
  logic        err_multi;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;
  int er_cnt   = 0;
  int es_cnt   = 0;
  int em_cnt   = 0;
  int et_cnt   = 0;

  matrix_scan_decoder #(
    .STABLE_CYCLES (4),
    .BOARD         (c_board),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst_full   (rst_full),
    .row_in     (row_in),
    .col_in     (col_in),
    .hex_in     (hex_in),
    .frame      (frame),
    .frame_valid(frame_valid),
    .pos        (pos),
    .pos_valid  (pos_valid),
    .dice       (dice),
    .dice_valid (dice_valid),
    .err_row    (err_row),
    .err_seq    (err_seq),
    .err_multi  (err_multi),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
    if (err_row     === 1'b1) er_cnt <= er_cnt + 1;
    if (err_seq     === 1'b1) es_cnt <= es_cnt + 1;
    if (err_multi   === 1'b1) em_cnt <= em_cnt + 1;
    if (err_timeout === 1'b1) et_cnt <= et_cnt + 1;
  end

  // Hold {row,col} for n cycles; returns 1 time unit after a rising edge.
  task automatic hold_rc(input logic [7:0] row, input logic [7:0] col, input int n);
    row_in = row;
    col_in = col;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_row(input int r, input logic [7:0] col);
    hold_rc(~(8'h01 << r), col, 20);
  endtask

  task automatic scan(input logic [63:0] f);
    for (int r = 0; r < 8; r++) send_row(r, f[8*r +: 8]);
    hold_rc(8'hFF, 8'h00, 10);
  endtask

  task automatic test_reset;
    rst_full = 1'b1;
    row_in   = 8'hFF;
    col_in   = 8'h00;
    hex_in   = 7'h7F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (frame !== 64'd0) begin
      n_fail++; $display("FAIL reset_frame: got %h expected %h", frame, 64'd0);
    end
    n_checks++;
    if ({pos, dice} !== 9'd0) begin
      n_fail++; $display("FAIL reset_pos_dice: got pos=%0d dice=%0d expected 0 0", pos, dice);
    end
    n_checks++;
    if ({frame_valid, pos_valid, dice_valid, err_row, err_seq, err_multi, err_timeout} !== 7'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000000",
        {frame_valid, pos_valid, dice_valid, err_row, err_seq, err_multi, err_timeout});
    end
    @(posedge clk); #1;
    rst_full = 1'b0;
    repeat (12) @(posedge clk); #1;
    n_checks++;
    if ({pos_valid, dice_valid, fv_cnt, er_cnt, es_cnt} !== {2'b00, 32'd0, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL idle_after_reset: got pv=%b dv=%b fv=%0d er=%0d es=%0d expected all 0",
        pos_valid, dice_valid, fv_cnt, er_cnt, es_cnt);
    end
  endtask

  task automatic test_board_scan;
    int fv0, e0;
    fv0 = fv_cnt;
    e0  = er_cnt + es_cnt + em_cnt;
    scan(c_board);
    n_checks++;
    if (frame !== c_board) begin
      n_fail++; $display("FAIL board_frame: got %h expected %h", frame, c_board);
    end
    n_checks++;
    if (fv_cnt - fv0 !== 1) begin
      n_fail++; $display("FAIL board_fv_count: got %0d expected 1", fv_cnt - fv0);
    end
    n_checks++;
    if (pos_valid !== 1'b0) begin
      n_fail++; $display("FAIL board_pos_valid: got %b expected 0", pos_valid);
    end
    n_checks++;
    if (er_cnt + es_cnt + em_cnt - e0 !== 0) begin
      n_fail++; $display("FAIL board_errors: got %0d expected 0", er_cnt + es_cnt + em_cnt - e0);
    end
  endtask

  task automatic test_player;
    logic [63:0] f;
    int fv0;
    f   = c_board | (64'd1 << 26);
    fv0 = fv_cnt;
    for (int r = 0; r < 7; r++) send_row(r, f[8*r +: 8]);
    row_in = ~8'h80;
    col_in = f[63:56];
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({frame_valid, pos_valid} !== 2'b10 || frame !== f) begin
      n_fail++; $display("FAIL player_commit_cycle: got fv=%b pv=%b frame=%h expected 1 0 %h",
        frame_valid, pos_valid, frame, f);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({frame_valid, pos_valid} !== 2'b01 || pos !== 6'd26) begin
      n_fail++; $display("FAIL player_pos_cycle: got fv=%b pv=%b pos=%0d expected 0 1 26",
        frame_valid, pos_valid, pos);
    end
    @(posedge clk); #1;
    hold_rc(~8'h80, f[63:56], 10);
    hold_rc(8'hFF, 8'h00, 10);
    n_checks++;
    if (fv_cnt - fv0 !== 1) begin
      n_fail++; $display("FAIL player_fv_count: got %0d expected 1", fv_cnt - fv0);
    end
    scan(c_board);
    n_checks++;
    if (pos !== 6'd26 || pos_valid !== 1'b1 || frame !== c_board) begin
      n_fail++; $display("FAIL player_hold: got pos=%0d pv=%b frame=%h expected 26 1 %h",
        pos, pos_valid, frame, c_board);
    end
  endtask

  task automatic test_seq_err;
    logic [63:0] f;
    int fv0, es0;
    fv0 = fv_cnt;
    es0 = es_cnt;
    send_row(0, c_board[7:0]);
    send_row(1, c_board[15:8]);
    send_row(3, c_board[31:24]);
    n_checks++;
    if (es_cnt - es0 !== 1 || frame !== c_board || fv_cnt - fv0 !== 0) begin
      n_fail++; $display("FAIL seq_skip: got es=%0d fv=%0d frame=%h expected 1 0 %h",
        es_cnt - es0, fv_cnt - fv0, frame, c_board);
    end
    for (int r = 4; r < 8; r++) send_row(r, c_board[8*r +: 8]);
    hold_rc(8'hFF, 8'h00, 10);
    n_checks++;
    if (es_cnt - es0 !== 1 || fv_cnt - fv0 !== 0) begin
      n_fail++; $display("FAIL seq_hunt_ignores: got es=%0d fv=%0d expected 1 0",
        es_cnt - es0, fv_cnt - fv0);
    end
    f = c_board | (64'd1 << 45);
    send_row(0, f[7:0]);
    send_row(1, f[15:8]);
    scan(f);
    n_checks++;
    if (es_cnt - es0 !== 2 || fv_cnt - fv0 !== 1 || frame !== f) begin
      n_fail++; $display("FAIL seq_restart: got es=%0d fv=%0d frame=%h expected 2 1 %h",
        es_cnt - es0, fv_cnt - fv0, frame, f);
    end
    n_checks++;
    if (pos !== 6'd45 || pos_valid !== 1'b1) begin
      n_fail++; $display("FAIL seq_restart_pos: got pos=%0d pv=%b expected 45 1", pos, pos_valid);
    end
  endtask

  task automatic test_row_err;
    int er0, es0, fv0;
    er0 = er_cnt;
    es0 = es_cnt;
    fv0 = fv_cnt;
    hold_rc(8'hF0, 8'h00, 10);
    n_checks++;
    if (er_cnt - er0 !== 1) begin
      n_fail++; $display("FAIL row_err_pulse: got %0d expected 1", er_cnt - er0);
    end
    hold_rc(8'hFF, 8'h00, 10);
    n_checks++;
    if (er_cnt - er0 !== 1) begin
      n_fail++; $display("FAIL row_blank_quiet: got %0d expected 1", er_cnt - er0);
    end
    for (int r = 0; r < 3; r++) send_row(r, c_board[8*r +: 8]);
    hold_rc(8'hF0, 8'h00, 10);
    for (int r = 3; r < 8; r++) send_row(r, c_board[8*r +: 8]);
    hold_rc(8'hFF, 8'h00, 10);
    n_checks++;
    if (er_cnt - er0 !== 2 || es_cnt - es0 !== 0 || fv_cnt - fv0 !== 0) begin
      n_fail++; $display("FAIL row_err_hunt: got er=%0d es=%0d fv=%0d expected 2 0 0",
        er_cnt - er0, es_cnt - es0, fv_cnt - fv0);
    end
  endtask

  task automatic test_multi;
    logic [63:0] f;
    int em0;
    em0 = em_cnt;
    f   = c_board | (64'd1 << 32) | (64'd1 << 44);
    scan(f);
    n_checks++;
    if (em_cnt - em0 !== 1 || pos_valid !== 1'b0) begin
      n_fail++; $display("FAIL multi_err: got em=%0d pv=%b expected 1 0", em_cnt - em0, pos_valid);
    end
    n_checks++;
    if (pos !== 6'd45 || frame !== f) begin
      n_fail++; $display("FAIL multi_hold: got pos=%0d frame=%h expected 45 %h", pos, frame, f);
    end
    f = c_board | (64'd1 << 10);
    scan(f);
    n_checks++;
    if (pos !== 6'd10 || pos_valid !== 1'b1 || em_cnt - em0 !== 1) begin
      n_fail++; $display("FAIL multi_recover: got pos=%0d pv=%b em=%0d expected 10 1 1",
        pos, pos_valid, em_cnt - em0);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] f;
    int fv0;
    f   = c_board | (64'd1 << 20);
    fv0 = fv_cnt;
    for (int r = 0; r < 3; r++) send_row(r, f[8*r +: 8]);
    hold_rc(~8'h08, f[31:24], 8);
    rst_full = 1'b1;
    @(negedge clk);
    n_checks++;
    if (frame !== 64'd0 || pos !== 6'd0 || pos_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_clear: got frame=%h pos=%0d pv=%b expected 0 0 0",
        frame, pos, pos_valid);
    end
    @(posedge clk); #1;
    rst_full = 1'b0;
    hold_rc(~8'h08, f[31:24], 10);
    for (int r = 4; r < 8; r++) send_row(r, f[8*r +: 8]);
    hold_rc(8'hFF, 8'h00, 10);
    n_checks++;
    if (fv_cnt - fv0 !== 0 || frame !== 64'd0) begin
      n_fail++; $display("FAIL reset_mid_discard: got fv=%0d frame=%h expected 0 0",
        fv_cnt - fv0, frame);
    end
    scan(c_board);
    n_checks++;
    if (fv_cnt - fv0 !== 1 || frame !== c_board) begin
      n_fail++; $display("FAIL reset_mid_resume: got fv=%0d frame=%h expected 1 %h",
        fv_cnt - fv0, frame, c_board);
    end
  endtask

  task automatic test_dice;
    logic [6:0] codes [6];
    int bad;
    codes = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010};
    hex_in = 7'b0110000;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dice !== 3'd0 || dice_valid !== 1'b0) begin
      n_fail++; $display("FAIL dice_early: got %0d/%b expected 0/0", dice, dice_valid);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dice !== 3'd3 || dice_valid !== 1'b1) begin
      n_fail++; $display("FAIL dice_three: got %0d/%b expected 3/1", dice, dice_valid);
    end
    repeat (4) @(posedge clk); #1;
    hex_in = 7'b0000010;
    repeat (10) @(posedge clk); #1;
    n_checks++;
    if (dice !== 3'd6 || dice_valid !== 1'b1) begin
      n_fail++; $display("FAIL dice_six: got %0d/%b expected 6/1", dice, dice_valid);
    end
    hex_in = 7'b1000000;
    repeat (10) @(posedge clk); #1;
    n_checks++;
    if (dice !== 3'd0 || dice_valid !== 1'b0) begin
      n_fail++; $display("FAIL dice_illegal: got %0d/%b expected 0/0", dice, dice_valid);
    end
    for (int i = 0; i < 6; i++) begin
      hex_in = codes[i];
      repeat (8) @(posedge clk); #1;
      n_checks++;
      if (dice !== 3'(i + 1) || dice_valid !== 1'b1) begin
        n_fail++; $display("FAIL dice_code_%0d: got %0d/%b expected %0d/1", i, dice, dice_valid, i + 1);
      end
    end
    hex_in = 7'b0110000;
    repeat (10) @(posedge clk); #1;
    hex_in = 7'b0100100;
    repeat (2) @(posedge clk); #1;
    hex_in = 7'b0110000;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dice !== 3'd3 || dice_valid !== 1'b1) bad++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL dice_glitch: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_timeout;
`ifdef SCAN_DECODER_TIMEOUT_EN
    logic [63:0] f;
    int et0, fv0;
    f = c_board | (64'd1 << 26);
    scan(f);
    n_checks++;
    if (pos_valid !== 1'b1) begin
      n_fail++; $display("FAIL timeout_pre: got pv=%b expected 1", pos_valid);
    end
    et0 = et_cnt;
    fv0 = fv_cnt;
    for (int r = 0; r < 3; r++) send_row(r, f[8*r +: 8]);
    row_in = ~8'h08;
    col_in = f[31:24];
    repeat (5) @(posedge clk);
    repeat (99) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: got %b expected 0", err_timeout);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (err_timeout !== 1'b1 || pos_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_fire: got et=%b pv=%b expected 1 0", err_timeout, pos_valid);
    end
    @(posedge clk); #1;
    for (int r = 4; r < 8; r++) send_row(r, f[8*r +: 8]);
    hold_rc(8'hFF, 8'h00, 10);
    n_checks++;
    if (et_cnt - et0 !== 1 || fv_cnt - fv0 !== 0) begin
      n_fail++; $display("FAIL timeout_hunt: got et=%0d fv=%0d expected 1 0", et_cnt - et0, fv_cnt - fv0);
    end
`else
    n_checks++;
    if (et_cnt !== 0) begin
      n_fail++; $display("FAIL timeout_absent: got %0d pulses expected 0", et_cnt);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_board_scan;
    test_player;
    test_seq_err;
    test_row_err;
    test_multi;
    test_reset_mid;
    test_dice;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Run-time bound for the whole bench.
  initial begin
    #400000;
    $display("FAIL bench_time_limit: run did not complete within 400000 time units");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/matrix_scan_decoder.md
# matrix_scan_decoder

Receive-side decoder for the snake-and-ladder board's 8x8 LED matrix scan and the dice 7-segment digit. It sits on the far end of the row/column scan bus and rebuilds full frames from the time-multiplexed row strobes. From each frame it extracts the player's cell by masking out the static board pattern. It also decodes the 7-segment code back to a dice value, for use by a second board, a logger, or the system-level checker.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronized samples of {row_in,col_in} (or hex_in) required before acceptance; range 2–255.
- BOARD, 64'h0802000081040250: static board pattern; row r occupies bits [8r+7:8r].
- TIMEOUT_CYCLES, 200000: watchdog limit; used only with SCAN_DECODER_TIMEOUT_EN.
- clk  in  1  system clock.
- rst_full  in  1  asynchronous, active-high reset.
- row_in  in  8  scan row select; active-low one-hot; 8'hFF means blank.
- col_in  in  8  column data for the selected row; bit c is column c.
- hex_in  in  7  active-low 7-segment code {g..a}.
- frame  out  64  last complete frame; row r in bits [8r+7:8r].
- frame_valid  out  1  one-cycle pulse when frame updates.
- pos  out  6  decoded player cell, row*8+col.
- pos_valid  out  1  level; pos is trustworthy.
- dice  out  3  decoded dice value 1–6, or 0.
- dice_valid  out  1  level; hex_in holds a legal dice code.
- err_row  out  1  pulse; stable illegal row pattern.
- err_seq  out  1  pulse; row accepted out of order.
- err_multi  out  1  pulse; more than one non-board cell lit.
- err_timeout  out  1  pulse; watchdog expired (0 when watchdog compiled out).

## Operation
- Synchronization:
  - row_in, col_in and hex_in each pass through a 2-flop synchronizer.
  - Synchronizer reset values: row 8'hFF, col 8'h00, hex 7'h7F.
- Row acceptance:
  - A counter tracks how long the synchronized {row,col} has been unchanged.
  - Acceptance fires exactly once, on the cycle the count reaches STABLE_CYCLES.
  - Acceptance re-arms only after {row,col} changes.
- Classification of a stable row pattern:
  - One-hot low (bit r = 0): row r accepted.
  - 8'hFF: ignored; no state change.
  - Any other value: err_row pulses and the FSM goes to HUNT.
- Frame FSM:
  - HUNT: accepted rows other than 0 are ignored. Row 0 stores col into shadow[0], sets exp=1, and moves to CAPTURE.
  - CAPTURE, accepted row == exp: store col into shadow[exp] and increment exp.
  - CAPTURE, accepted row 7 (completing the frame): commit shadow to frame, pulse frame_valid, then go to HUNT.
  - CAPTURE, accepted row != exp: err_seq pulses. If the row is 0, restart capture at exp=1; otherwise go to HUNT.
- Position decode, run on each committed frame:
  - Compute ov = frame & ~BOARD.
  - popcount(ov) == 1: pos = index of the set bit; pos_valid = 1.
  - popcount(ov) == 0 (blink off phase, or player hidden on a lit board cell): pos and pos_valid hold.
  - popcount(ov) > 1: err_multi pulses, pos_valid = 0, pos holds.
- Dice decode:
  - Uses synchronized hex_in, stable for STABLE_CYCLES.
  - Legal codes: 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6. Each sets dice and dice_valid = 1.
  - Any other stable code sets dice = 0 and dice_valid = 0.
  - While hex_in is unstable, dice and dice_valid hold.

## Timing
- Reset values: all outputs 0, shadow cleared, FSM in HUNT, stability counters 0.
- Reset mid-frame discards the partial shadow; frame and pos are cleared.
- Input change at cycle t:
  - Synchronized at t+2.
  - Row acceptance at t+1+STABLE_CYCLES, when the first synchronized sample counts as 1.
- Row 7 accepted at cycle A: frame and frame_valid at A+1; pos, pos_valid and err_multi at A+2.
- Dice outputs update 1 cycle after hex stability is reached.
- Every error output is a single-cycle pulse; several may assert in the same cycle.
- Row acceptance and err_row are mutually exclusive, since a pattern is classified only once.

## Configuration
- SCAN_DECODER_TIMEOUT_EN defined:
  - A watchdog counts cycles since the last row acceptance and reloads on every acceptance.
  - At TIMEOUT_CYCLES: err_timeout pulses, the FSM goes to HUNT, and pos_valid clears.
  - If acceptance and expiry coincide, acceptance wins.
- Not defined: no watchdog logic; err_timeout is tied to 0.

## Test plan
- Board-only scan, rows 0..7, each held 20 cycles, STABLE_CYCLES=4: frame == 64'h0802000081040250, frame_valid pulses once per scan, pos_valid stays 0.
- Same scan with bit 2 set in row 3 (col 8'h85): pos = 26 and pos_valid = 1 two cycles after the row-7 acceptance. The next frame without the extra bit leaves pos = 26 held.
- Rows sent 0,1,3: err_seq pulses on row 3, the FSM is in HUNT, and frame is unchanged. A following clean scan commits normally.
- row_in = 8'hF0 held 10 cycles: a single err_row pulse. row_in = 8'hFF held 10 cycles: no error.
- Two non-board cells lit in one frame: err_multi pulses and pos_valid = 0.
- hex_in stepped through 0110000, 0000010, 1000000 with 10-cycle dwells: dice reads 3, then 6, then 0 (dice_valid 0). A 2-cycle glitch to 0100100 is not reported.
- With SCAN_DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=100: the scan stops mid-frame, and err_timeout pulses exactly 100 cycles after the last acceptance.
